// File: rtl/motion_bbox_detector.sv
// motion_bbox_detector: frame-difference motion detector reporting pixel count, bounding box and centre
module motion_bbox_detector #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  threshold,
    output logic        oe,
    output logic [14:0] rAddr,
    input  logic [7:0]  curr_frame_data,
    input  logic [7:0]  prev_frame_data,
    output logic        busy,
    output logic        done,
    output logic        motion_valid,
    output logic [14:0] motion_count,
    output logic [7:0]  x_min,
    output logic [7:0]  x_max,
    output logic [6:0]  y_min,
    output logic [6:0]  y_max,
    output logic [7:0]  center_x,
    output logic [6:0]  center_y
);
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, CALC, DONE} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_thr, r_x, r_px, r_xmin, r_xmax, w_cx;
    logic [6:0]  r_y, r_py, r_ymin, r_ymax, w_cy;
    logic [14:0] r_addr, r_cnt;
    logic [8:0]  w_diff;
    logic        r_dv, w_last, w_xwrap, w_motion, w_go, w_none;
    assign w_go     = r_state == IDLE && start;
    assign w_last   = r_addr == 15'(WIDTH * HEIGHT - 1);
    assign w_xwrap  = r_x == 8'(WIDTH - 1);
    assign w_diff   = curr_frame_data >= prev_frame_data ? {1'b0, curr_frame_data} - {1'b0, prev_frame_data}
                                                         : {1'b0, prev_frame_data} - {1'b0, curr_frame_data};
    assign w_motion = r_dv && w_diff > {1'b0, r_thr};
    assign w_none   = r_cnt == '0;
    assign w_cx     = 8'(({1'b0, r_xmin} + {1'b0, r_xmax}) >> 1);
    assign w_cy     = 7'(({1'b0, r_ymin} + {1'b0, r_ymax}) >> 1);
    assign rAddr    = r_addr;
    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // next-state and control outputs
    always_comb begin
        w_next = r_state;
        oe     = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = SCAN;
            end
            SCAN: begin
                oe = 1'b1;
                if (w_last) w_next = DRAIN;
            end
            DRAIN:   w_next = CALC;
            CALC:    w_next = DONE;
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // address generator; coordinates delayed one cycle to line up with returned pixels
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_px   <= '0;
            r_py   <= '0;
            r_dv   <= 1'b0;
            r_thr  <= '0;
        end else begin
            r_dv <= r_state == SCAN;
            r_px <= r_x;
            r_py <= r_y;
            if (w_go) begin
                r_thr  <= threshold;
                r_addr <= '0;
                r_x    <= '0;
                r_y    <= '0;
            end else if (r_state == SCAN) begin
                r_addr <= w_last ? '0 : r_addr + 15'd1;
                r_x    <= w_xwrap ? '0 : r_x + 8'd1;
                r_y    <= w_last ? '0 : w_xwrap ? r_y + 7'd1 : r_y;
            end
        end
    end
    // motion accumulators: count and running bounding box
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
        end else if (w_go) begin
            r_cnt  <= '0;
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
        end else if (w_motion) begin
            r_cnt  <= r_cnt + 15'd1;
            r_xmin <= r_px < r_xmin ? r_px : r_xmin;
            r_xmax <= r_px > r_xmax ? r_px : r_xmax;
            r_ymin <= r_py < r_ymin ? r_py : r_ymin;
            r_ymax <= r_py > r_ymax ? r_py : r_ymax;
        end
    end
    // result registers, loaded in CALC and held until the next CALC
    always_ff @(posedge clk) begin
        if (reset) begin
            motion_count <= '0;
            motion_valid <= 1'b0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            center_x     <= '0;
            center_y     <= '0;
        end else if (r_state == CALC) begin
            motion_count <= r_cnt;
            motion_valid <= r_cnt >= 15'(MIN_PIXELS);
            x_min        <= w_none ? '0 : r_xmin;
            x_max        <= w_none ? '0 : r_xmax;
            y_min        <= w_none ? '0 : r_ymin;
            y_max        <= w_none ? '0 : r_ymax;
            center_x     <= w_none ? '0 : w_cx;
            center_y     <= w_none ? '0 : w_cy;
        end
    end
endmodule

// File: tb/tb_motion_bbox_detector.sv
// tb_motion_bbox_detector: scoreboard bench with frame-buffer model and behavioural reference
module tb_motion_bbox_detector;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
    typedef struct {
        int cnt, valid, xmin, xmax, ymin, ymax, cx, cy, c0;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset, start, oe, busy, done, motion_valid;
    logic [7:0]  threshold, curr_frame_data, prev_frame_data, x_min, x_max, center_x;
    logic [14:0] rAddr, motion_count;
    logic [6:0]  y_min, y_max, center_y;
    logic [7:0]  cur_m [N];
    logic [7:0]  prv_m [N];
    exp_t        q[$];
    exp_t        m_e;
    int          errors = 0, checks = 0, cyc = 0, oe_cnt = 0, addr_bad = 0;
    motion_bbox_detector dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .oe(oe), .rAddr(rAddr), .curr_frame_data(curr_frame_data), .prev_frame_data(prev_frame_data),
        .busy(busy), .done(done), .motion_valid(motion_valid), .motion_count(motion_count),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .center_x(center_x), .center_y(center_y)
    );
    always #5 clk = ~clk;
    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;
    // frame buffer: registered read, data one cycle after oe/rAddr
    always @(posedge clk) begin
        if (oe) begin
            curr_frame_data <= cur_m[rAddr];
            prev_frame_data <= prv_m[rAddr];
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic exp_t model(input int thr);
        exp_t e;
        int d;
        e = '{default: 0};
        e.xmin = 255;
        e.ymin = 127;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                d = int'(cur_m[y * W + x]) - int'(prv_m[y * W + x]);
                if (d < 0) d = -d;
                if (d > thr) begin
                    e.cnt++;
                    if (x < e.xmin) e.xmin = x;
                    if (x > e.xmax) e.xmax = x;
                    if (y < e.ymin) e.ymin = y;
                    if (y > e.ymax) e.ymax = y;
                end
            end
        if (e.cnt == 0) begin
            e.xmin = 0;
            e.ymin = 0;
        end
        e.cx    = (e.xmin + e.xmax) / 2;
        e.cy    = (e.ymin + e.ymax) / 2;
        e.valid = e.cnt >= 16 ? 1 : 0;
        return e;
    endfunction
    // monitor: address sequence tracking and result comparison on every done pulse
    always @(negedge clk) begin
        if (oe) begin
            if (int'(rAddr) != oe_cnt) addr_bad++;
            if (oe_cnt == 160) chk("addr_x0_y1", int'(rAddr), 160);
            oe_cnt++;
        end
        if (done) begin
            chk("done_pending", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                m_e = q.pop_front();
                chk("latency", cyc - m_e.c0, N + 3);
                chk("count", int'(motion_count), m_e.cnt);
                chk("valid", int'(motion_valid), m_e.valid);
                chk("x_min", int'(x_min), m_e.xmin);
                chk("x_max", int'(x_max), m_e.xmax);
                chk("y_min", int'(y_min), m_e.ymin);
                chk("y_max", int'(y_max), m_e.ymax);
                chk("center_x", int'(center_x), m_e.cx);
                chk("center_y", int'(center_y), m_e.cy);
                chk("oe_cycles", oe_cnt, N);
                chk("addr_errors", addr_bad, 0);
                chk("busy_at_done", int'(busy), 1);
            end
            oe_cnt   = 0;
            addr_bad = 0;
        end else if (!busy) begin
            oe_cnt   = 0;
            addr_bad = 0;
        end
    end
    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_oe"}, int'(oe), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rAddr"}, int'(rAddr), 0);
        chk({tag, "_count"}, int'(motion_count), 0);
        chk({tag, "_valid"}, int'(motion_valid), 0);
        chk({tag, "_bbox"}, int'({x_min, x_max, y_min, y_max}), 0);
        chk({tag, "_center"}, int'({center_x, center_y}), 0);
    endtask
    task automatic do_start(input int thr, input bit push);
        exp_t e;
        if (push) begin
            e    = model(thr);
            e.c0 = cyc;
            q.push_back(e);
        end
        threshold = 8'(thr);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        threshold = 8'($urandom);
    endtask
    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < N + 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(done), 1);
    endtask
    task automatic fill_same();
        for (int i = 0; i < N; i++) begin
            prv_m[i] = 8'($urandom);
            cur_m[i] = prv_m[i];
        end
    endtask
    // stimulus
    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b1;
        threshold = 8'hff;
        fill_same();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_zero("reset");
        // 8x8 block differing by 50, with stray starts during the scan
        fill_same();
        for (int y = 30; y < 38; y++)
            for (int x = 40; x < 48; x++)
                cur_m[y * W + x] = prv_m[y * W + x] >= 128 ? 8'(prv_m[y * W + x] - 8'd50) : 8'(prv_m[y * W + x] + 8'd50);
        do_start(20, 1);
        repeat (1000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_block");
        start = 1'b1;
        fill_same();
        prv_m[0]     = 8'($urandom_range(0, 200));
        cur_m[0]     = prv_m[0] + 8'd30;
        prv_m[N - 1] = 8'($urandom_range(0, 200));
        cur_m[N - 1] = prv_m[N - 1] + 8'd31;
        @(negedge clk);
        do_start(30, 1);
        repeat (100) @(negedge clk);
        chk("hold_count", int'(motion_count), 64);
        chk("hold_center_x", int'(center_x), 43);
        wait_done("done_corner");
        // identical frames after a non-zero result
        @(negedge clk);
        fill_same();
        do_start(10, 1);
        wait_done("done_identical");
        // abort with reset at address 5000
        @(negedge clk);
        fill_same();
        do_start($urandom_range(0, 255), 0);
        n = 0;
        while (!(oe && rAddr == 15'd5000) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_5000", int'(rAddr), 5000);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort");
        reset = 1'b0;
        repeat (50) @(negedge clk);
        // sparse random motion with random threshold
        fill_same();
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 299) == 0) cur_m[i] = 8'($urandom);
        do_start($urandom_range(5, 60), 1);
        wait_done("done_random");
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
